// File: rtl/result_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : result_uart_tx
//  Purpose  : Queues processor quotients in a small FIFO and sends each one
//             as zero-padded big-endian bytes over an 8N1 UART line.
//             Define RESULT_UART_SYNC_BYTE_EN to prefix every frame with 0xA5.
//  Revision : 1.0 - initial release
// ============================================================================
module result_uart_tx #(
    parameter int DATA_SIZE    = 10,
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [2*DATA_SIZE-1:0] i_result,
    input  logic                   i_valid,
    output logic                   o_tx,
    output logic                   o_busy,
    output logic                   o_overflow
);

    localparam int c_RES_W     = 2 * DATA_SIZE;
    localparam int c_NBYTES    = (c_RES_W + 7) / 8;
    localparam int c_PAYLOAD_W = c_NBYTES * 8;
`ifdef RESULT_UART_SYNC_BYTE_EN
    localparam int c_NFRAME    = c_NBYTES + 1;
    localparam logic [7:0] c_SYNC_BYTE = 8'hA5;
`else
    localparam int c_NFRAME    = c_NBYTES;
`endif
    localparam int c_FRAME_W   = c_NFRAME * 8;
    localparam int c_CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_BCNT_W    = $clog2(c_NFRAME + 1);
    localparam int c_PTR_W     = $clog2(FIFO_DEPTH);

    localparam logic [c_CNT_W-1:0]  c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BCNT_W-1:0] c_BYTE_LAST = c_BCNT_W'(c_NFRAME - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_START = 2'd1;
    localparam logic [1:0] c_S_DATA  = 2'd2;
    localparam logic [1:0] c_S_STOP  = 2'd3;

    // ------------------------------------------------------------------
    // Result FIFO (pointers carry one wrap bit to tell full from empty)
    // ------------------------------------------------------------------
    logic [c_RES_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W:0]   r_wr_ptr;
    logic [c_PTR_W:0]   r_rd_ptr;
    logic               r_overflow;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic [c_RES_W-1:0] w_head;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                     (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    // A pop in the same cycle frees the slot the write needs.
    assign w_push  = i_valid && !i_reset && (!w_full || w_pop);
    assign w_drop  = i_valid && !i_reset && w_full && !w_pop;
    assign w_head  = r_mem[r_rd_ptr[c_PTR_W-1:0]];

    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= i_result;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (c_PTR_W + 1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (c_PTR_W + 1)'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame loading
    // ------------------------------------------------------------------
    logic [c_PAYLOAD_W-1:0] w_payload;
    logic [c_FRAME_W-1:0]   w_load;

    assign w_payload = c_PAYLOAD_W'(w_head);
`ifdef RESULT_UART_SYNC_BYTE_EN
    assign w_load    = {c_SYNC_BYTE, w_payload};
`else
    assign w_load    = w_payload;
`endif

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    logic [1:0]           r_state;
    logic [c_CNT_W-1:0]   r_clk_cnt;
    logic [2:0]           r_bit_idx;
    logic [c_BCNT_W-1:0]  r_byte_cnt;
    logic [c_FRAME_W-1:0] r_frame;
    logic                 r_tx;

    logic [1:0]           w_state_nxt;
    logic [c_CNT_W-1:0]   w_clk_cnt_nxt;
    logic [2:0]           w_bit_idx_nxt;
    logic [c_BCNT_W-1:0]  w_byte_cnt_nxt;
    logic [c_FRAME_W-1:0] w_frame_nxt;
    logic                 w_tx_nxt;
    logic                 w_bit_done;
    logic [7:0]           w_cur_byte;

    assign w_bit_done = (r_clk_cnt == c_BIT_LAST);
    // The byte on the wire always sits at the top of the frame register.
    assign w_cur_byte = r_frame[c_FRAME_W-1 -: 8];

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= c_S_IDLE;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_byte_cnt <= '0;
            r_frame    <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_clk_cnt  <= w_clk_cnt_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_frame    <= w_frame_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clk_cnt_nxt  = r_clk_cnt;
        w_bit_idx_nxt  = r_bit_idx;
        w_byte_cnt_nxt = r_byte_cnt;
        w_frame_nxt    = r_frame;
        w_tx_nxt       = r_tx;
        w_pop          = 1'b0;

        case (r_state)
            c_S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_empty) begin
                    w_pop          = 1'b1;
                    w_frame_nxt    = w_load;
                    w_byte_cnt_nxt = '0;
                    w_clk_cnt_nxt  = '0;
                    w_bit_idx_nxt  = '0;
                    w_tx_nxt       = 1'b0;
                    w_state_nxt    = c_S_START;
                end
            end

            c_S_START: begin
                if (w_bit_done) begin
                    w_clk_cnt_nxt = '0;
                    w_bit_idx_nxt = '0;
                    w_tx_nxt      = w_cur_byte[0];
                    w_state_nxt   = c_S_DATA;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + c_CNT_W'(1);
                end
            end

            c_S_DATA: begin
                if (w_bit_done) begin
                    w_clk_cnt_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = c_S_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_tx_nxt      = w_cur_byte[r_bit_idx + 3'd1];
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + c_CNT_W'(1);
                end
            end

            c_S_STOP: begin
                if (w_bit_done) begin
                    w_clk_cnt_nxt = '0;
                    if (r_byte_cnt == c_BYTE_LAST) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = c_S_IDLE;
                    end else begin
                        // Next byte follows the stop bit with no gap.
                        w_byte_cnt_nxt = r_byte_cnt + c_BCNT_W'(1);
                        w_frame_nxt    = r_frame << 8;
                        w_tx_nxt       = 1'b0;
                        w_state_nxt    = c_S_START;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + c_CNT_W'(1);
                end
            end

            default: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    assign o_tx       = r_tx;
    assign o_busy     = (r_state != c_S_IDLE) || !w_empty;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_result_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_result_uart_tx
//  Purpose  : Self-checking bench for result_uart_tx; line samples are decoded
//             into bytes and compared with a byte-stream model of each result.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_result_uart_tx;

    localparam int DATA_SIZE = 10;
    localparam int CPB       = 4;
    localparam int DEPTH     = 4;
    localparam int RES_W     = 2 * DATA_SIZE;
    localparam int NBYTES    = (RES_W + 7) / 8;
`ifdef RESULT_UART_SYNC_BYTE_EN
    localparam int NFRAME    = NBYTES + 1;
`else
    localparam int NFRAME    = NBYTES;
`endif
    localparam int BYTE_CYC  = 10 * CPB;
    localparam int FRAME_CYC = NFRAME * BYTE_CYC;

    logic             clk = 1'b0;
    logic             rst;
    logic [RES_W-1:0] res;
    logic             valid;
    logic             tx;
    logic             busy;
    logic             ovf;

    int         checks   = 0;
    int         failures = 0;
    logic       tx_q[$];
    logic       busy_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         start_q[$];
    int         frame_err;

    result_uart_tx #(
        .DATA_SIZE   (DATA_SIZE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .i_clock   (clk),
        .i_reset   (rst),
        .i_result  (res),
        .i_valid   (valid),
        .o_tx      (tx),
        .o_busy    (busy),
        .o_overflow(ovf)
    );

    always #5 clk = ~clk;

    // Sample index k holds the outputs just after the k-th edge since clear().
    task automatic tick();
        @(posedge clk);
        #1;
        tx_q.push_back(tx);
        busy_q.push_back(busy);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear();
        tx_q.delete();
        busy_q.delete();
        exp_q.delete();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte-stream model: optional sync byte, then the result MSB-first.
    task automatic expect_result(input logic [RES_W-1:0] v);
        longint val;
        val = longint'(v);
`ifdef RESULT_UART_SYNC_BYTE_EN
        exp_q.push_back(8'hA5);
`endif
        for (int b = NBYTES - 1; b >= 0; b--) begin
            exp_q.push_back(8'((val >> (8 * b)) & 255));
        end
    endtask

    // 8N1 receiver over the recorded line samples.
    task automatic decode();
        int         i;
        int         s;
        logic [7:0] b;
        i = 0;
        rx_q.delete();
        start_q.delete();
        frame_err = 0;
        while (i + BYTE_CYC <= tx_q.size()) begin
            if (tx_q[i] === 1'b0) begin
                s = i;
                for (int j = 0; j < CPB; j++) if (tx_q[s + j] !== 1'b0) frame_err++;
                for (int k = 0; k < 8; k++) b[k] = tx_q[s + CPB * (1 + k) + CPB / 2];
                for (int j = 0; j < CPB; j++) if (tx_q[s + 9 * CPB + j] !== 1'b1) frame_err++;
                rx_q.push_back(b);
                start_q.push_back(s);
                i = s + BYTE_CYC;
            end else begin
                i++;
            end
        end
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        check({tag, "_framing"}, frame_err, 0);
        for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++) begin
            check($sformatf("%s_byte%0d", tag, k), rx_q[k], exp_q[k]);
        end
    endtask

    initial begin
        int               n;
        logic [RES_W-1:0] rv;

        rst   = 1'b1;
        valid = 1'b0;
        res   = '0;

        // Reset state and a quiet line afterwards.
        ticks(5);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;
        clear();
        ticks(100);
        n = 0;
        foreach (tx_q[k]) if (tx_q[k] !== 1'b1) n++;
        check("rst_quiet", n, 0);

        // Single result with latency and busy length.
        clear();
        res   = 20'hABCDE;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        res   = '0;
        tick();
        ticks(FRAME_CYC + 10);
        check("single_tx_at_capture", tx_q[0], 1);
        check("single_busy_rise", busy_q[0], 1);
        check("single_tx_fall", tx_q[1], 0);
        n = 0;
        foreach (busy_q[k]) if (busy_q[k] === 1'b1) n++;
        check("single_busy_len", n, FRAME_CYC + 1);
        expect_result(20'hABCDE);
        decode();
        compare_stream("single");

        // Back-to-back results on consecutive cycles.
        clear();
        res   = 20'h00001;
        valid = 1'b1;
        tick();
        res   = 20'hFFFFF;
        tick();
        valid = 1'b0;
        ticks(2 * FRAME_CYC + 20);
        expect_result(20'h00001);
        expect_result(20'hFFFFF);
        decode();
        compare_stream("b2b");
        if (start_q.size() == 2 * NFRAME) begin
            check("b2b_intra_gap", start_q[1] - start_q[0], BYTE_CYC);
            check("b2b_frame_gap", start_q[NFRAME] - start_q[NFRAME-1], BYTE_CYC + 1);
            check("b2b_idle_high", tx_q[start_q[NFRAME] - 1], 1);
        end
        check("b2b_no_ovf", ovf, 0);

        // Randomised results: spaced out, then a burst that fits the FIFO.
        clear();
        for (int r = 0; r < 4; r++) begin
            rv    = RES_W'($urandom);
            res   = rv;
            valid = 1'b1;
            tick();
            valid = 1'b0;
            expect_result(rv);
            ticks($urandom_range(FRAME_CYC + 60, FRAME_CYC + 2));
        end
        for (int r = 0; r < DEPTH; r++) begin
            rv    = RES_W'($urandom);
            res   = rv;
            valid = 1'b1;
            tick();
            expect_result(rv);
        end
        valid = 1'b0;
        ticks(DEPTH * (FRAME_CYC + 1) + 20);
        decode();
        compare_stream("rand");
        check("rand_no_ovf", ovf, 0);
        check("rand_busy_end", busy, 0);

        // Overflow: six strobes into a four-entry FIFO.
        clear();
        valid = 1'b1;
        for (int v = 1; v <= 6; v++) begin
            res = RES_W'(v);
            tick();
        end
        valid = 1'b0;
        check("ovf_flag", ovf, 1);
        ticks(5 * (FRAME_CYC + 1) + 30);
        check("ovf_sticky", ovf, 1);
        check("ovf_busy_end", busy, 0);
        for (int v = 1; v <= 5; v++) expect_result(RES_W'(v));
        decode();
        compare_stream("ovf");

        // Mid-frame reset with queued results and a strobe held during reset.
        clear();
        valid = 1'b1;
        res   = 20'h13579;
        tick();
        res   = 20'h2468A;
        tick();
        res   = 20'h11111;
        tick();
        valid = 1'b0;
        ticks(BYTE_CYC + 15);
        check("mr_tx_low_before", tx, 0);
        rst   = 1'b1;
        valid = 1'b1;
        res   = 20'h77777;
        tick();
        check("mr_tx", tx, 1);
        check("mr_busy", busy, 0);
        check("mr_ovf", ovf, 0);
        rst   = 1'b0;
        valid = 1'b0;
        clear();
        ticks(5);
        n = 0;
        foreach (busy_q[k]) if (busy_q[k] !== 1'b0 || tx_q[k] !== 1'b1) n++;
        check("mr_flushed", n, 0);
        clear();
        res   = 20'h5A5A5;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        ticks(FRAME_CYC + 20);
        expect_result(20'h5A5A5);
        decode();
        compare_stream("mr_new");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
